// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 init sequencer: FSM states, register
// addresses and the serial command word width.
package max7219_pkg;

  localparam int CMD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_GAP,
    ST_FIN
  } state_e;

  localparam logic [7:0] REG_NOOP      = 8'h00;
  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DIGIT1    = 8'h02;
  localparam logic [7:0] REG_DIGIT2    = 8'h03;
  localparam logic [7:0] REG_DIGIT3    = 8'h04;
  localparam logic [7:0] REG_DIGIT4    = 8'h05;
  localparam logic [7:0] REG_DIGIT5    = 8'h06;
  localparam logic [7:0] REG_DIGIT6    = 8'h07;
  localparam logic [7:0] REG_DIGIT7    = 8'h08;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

endpackage

// File: rtl/max7219_cmd_rom.sv
// Combinational table of MAX7219 power-up commands (address byte, data byte).
// Indices at or beyond DEPTH read back as a no-op word.
module max7219_cmd_rom
  import max7219_pkg::*;
#(
  parameter int DEPTH = 13
) (
  input  logic [3:0]       idx_i,
  output logic [CMD_W-1:0] word_o
);

  logic [CMD_W-1:0] word;

  always_comb begin
    word = {REG_NOOP, 8'h00};
    case (idx_i)
      4'd0:    word = {REG_SHUTDOWN,  8'h01};
      4'd1:    word = {REG_DECODE,    8'hFF};
      4'd2:    word = {REG_INTENSITY, 8'h0F};
      4'd3:    word = {REG_SCANLIMIT, 8'h07};
      4'd4:    word = {REG_TEST,      8'h00};
      4'd5:    word = {REG_DIGIT0,    8'h01};
      4'd6:    word = {REG_DIGIT1,    8'h02};
      4'd7:    word = {REG_DIGIT2,    8'h03};
      4'd8:    word = {REG_DIGIT3,    8'h04};
      4'd9:    word = {REG_DIGIT4,    8'h05};
      4'd10:   word = {REG_DIGIT5,    8'h06};
      4'd11:   word = {REG_DIGIT6,    8'h07};
      4'd12:   word = {REG_DIGIT7,    8'h08};
      default: word = {REG_NOOP,      8'h00};
    endcase
    if (int'(idx_i) >= DEPTH) begin
      word = {REG_NOOP, 8'h00};
    end
  end

  assign word_o = word;

endmodule

// File: rtl/max7219_seq.sv
// Serialises the command ROM into a chain of N_DEV MAX7219s: each command is
// shifted MSB-first once per device, then latched with a LOAD pulse.
module max7219_seq
  import max7219_pkg::*;
#(
  parameter int N_DEV   = 1,
  parameter int DEPTH   = 13,
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] cmd_idx_o,
  output logic       max_din_o,
  output logic       max_clk_o,
  output logic       max_load_o
);

  localparam int BITS  = CMD_W * N_DEV;
  localparam int BIT_W = $clog2(BITS);
  localparam int DIV_W = $clog2(2 * CLK_DIV);

  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(BITS - 1);
  localparam logic [DIV_W-1:0] DIV_HALF      = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_BIT_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [3:0]       IDX_LAST      = 4'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [3:0]       idx_q, idx_d;
  logic             din_q, din_d;
  logic             clk_q, clk_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [CMD_W-1:0] word_d;

  // The ROM is addressed with the next index so the outputs can be
  // registered from next-state values and stay aligned with the state.
  max7219_cmd_rom #(
    .DEPTH (DEPTH)
  ) u_rom (
    .idx_i  (idx_d),
    .word_o (word_d)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = BIT_LAST;
          idx_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_BIT_LAST) begin
          div_d = '0;
          if (bit_q == '0) begin
            state_d = ST_LOAD;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LOAD: begin
        if (div_q == DIV_HALF_LAST) begin
          div_d   = '0;
          state_d = ST_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (div_q == DIV_HALF_LAST) begin
          div_d = '0;
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + 4'd1;
            bit_d   = BIT_LAST;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The low nibble of the down-counter walks 15..0 once per device, which
    // repeats the word N_DEV times MSB-first without a separate device count.
    din_d  = (state_d == ST_SHIFT) && word_d[bit_d[3:0]];
    clk_d  = (state_d == ST_SHIFT) && (div_d >= DIV_HALF);
    load_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_FIN);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      din_q   <= 1'b0;
      clk_q   <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      clk_q   <= clk_d;
      load_q  <= load_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cmd_idx_o  = idx_q;
  assign max_din_o  = din_q;
  assign max_clk_o  = clk_q;
  assign max_load_o = load_q;

endmodule

// File: tb/tb_max7219_seq.sv
// Bench for max7219_seq: four differently parameterised instances, each with
// a bus monitor that decodes latched frames and checks serial timing.
`timescale 1ns/1ps
module tb_max7219_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_r;
  logic [3:0] start_r;
  logic [3:0] mon_clr;
  wire  [3:0] busy_w, done_w, din_w, mclk_w, load_w;
  wire  [3:0] idx_w [4];

  int checks = 0;
  int errors = 0;

  function automatic int cd_of(input int i);
    int r;
    case (i)
      0: r = 2;
      1: r = 1;
      2: r = 1;
      default: r = 7;
    endcase
    return r;
  endfunction

  function automatic int nd_of(input int i);
    int r;
    case (i)
      0: r = 1;
      1: r = 4;
      2: r = 1;
      default: r = 2;
    endcase
    return r;
  endfunction

  function automatic int dep_of(input int i);
    int r;
    case (i)
      0: r = 13;
      1: r = 2;
      2: r = 3;
      default: r = 2;
    endcase
    return r;
  endfunction

  // Cycles per command: 16*N bits of 2*CD cycles, then LOAD and GAP of CD each.
  function automatic int per_of(input int i);
    return 32 * nd_of(i) * cd_of(i) + 2 * cd_of(i);
  endfunction

  function automatic logic [15:0] rom_word(input int k);
    logic [15:0] w;
    case (k)
      0: w = 16'h0C01;
      1: w = 16'h09FF;
      2: w = 16'h0A0F;
      3: w = 16'h0B07;
      4: w = 16'h0F00;
      default: w = (k >= 5 && k <= 12) ? {8'(k - 4), 8'(k - 4)} : 16'h0000;
    endcase
    return w;
  endfunction

  function automatic logic [63:0] exp_frame(input int i, input int k);
    logic [63:0] f;
    f = '0;
    for (int r = 0; r < nd_of(i); r++) f = {f[47:0], rom_word(k)};
    return f;
  endfunction

  max7219_seq #(.N_DEV(1), .DEPTH(13), .CLK_DIV(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst_r[0]), .start_i(start_r[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .cmd_idx_o(idx_w[0]), .max_din_o(din_w[0]),
    .max_clk_o(mclk_w[0]), .max_load_o(load_w[0]));
  max7219_seq #(.N_DEV(4), .DEPTH(2), .CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_r[1]), .start_i(start_r[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .cmd_idx_o(idx_w[1]), .max_din_o(din_w[1]),
    .max_clk_o(mclk_w[1]), .max_load_o(load_w[1]));
  max7219_seq #(.N_DEV(1), .DEPTH(3), .CLK_DIV(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst_r[2]), .start_i(start_r[2]), .busy_o(busy_w[2]),
    .done_o(done_w[2]), .cmd_idx_o(idx_w[2]), .max_din_o(din_w[2]),
    .max_clk_o(mclk_w[2]), .max_load_o(load_w[2]));
  max7219_seq #(.N_DEV(2), .DEPTH(2), .CLK_DIV(7)) u_dut3 (
    .clk_i(clk), .rst_i(rst_r[3]), .start_i(start_r[3]), .busy_o(busy_w[3]),
    .done_o(done_w[3]), .cmd_idx_o(idx_w[3]), .max_din_o(din_w[3]),
    .max_clk_o(mclk_w[3]), .max_load_o(load_w[3]));

  // One sample per clk cycle on the falling edge, away from output updates.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    localparam int CD = cd_of(g);
    logic        p_clk, p_din, p_load, p_done, rise_din;
    int          clk_run, din_age, load_run, nbits, nframes;
    int          done_cnt, stab_err, phase_err, load_bad, done_bad;
    logic [63:0] shreg;
    logic [63:0] frames [16];
    int          fbits [16];

    always @(negedge clk) begin
      p_clk  <= mclk_w[g];
      p_din  <= din_w[g];
      p_load <= load_w[g];
      p_done <= done_w[g];
      if (mon_clr[g]) begin
        rise_din <= 1'b0;
        clk_run <= 0; din_age <= 0; load_run <= 0; nbits <= 0; nframes <= 0;
        done_cnt <= 0; stab_err <= 0; phase_err <= 0; load_bad <= 0; done_bad <= 0;
        shreg <= '0;
      end else begin
        clk_run  <= (mclk_w[g] == p_clk) ? clk_run + 1 : 1;
        din_age  <= (din_w[g] == p_din) ? din_age + 1 : 1;
        load_run <= load_w[g] ? (p_load ? load_run + 1 : 1) : 0;
        if (mclk_w[g] && !p_clk) begin
          shreg    <= {shreg[62:0], din_w[g]};
          nbits    <= nbits + 1;
          rise_din <= din_w[g];
          if (din_w[g] != p_din || din_age < CD) stab_err <= stab_err + 1;
          if (nbits != 0 && clk_run != CD) phase_err <= phase_err + 1;
        end else if (mclk_w[g] && din_w[g] != rise_din) begin
          stab_err <= stab_err + 1;
        end else if (!mclk_w[g] && p_clk && clk_run != CD) begin
          phase_err <= phase_err + 1;
        end
        if (load_w[g] && !p_load) begin
          if (nframes < 16) begin
            frames[nframes[3:0]] <= shreg;
            fbits[nframes[3:0]]  <= nbits;
          end
          nframes <= nframes + 1;
          nbits   <= 0;
          shreg   <= '0;
        end
        if (load_w[g] && mclk_w[g]) load_bad <= load_bad + 1;
        else if (!load_w[g] && p_load && load_run != CD) load_bad <= load_bad + 1;
        if (done_w[g]) begin
          done_cnt <= done_cnt + 1;
          if (p_done) done_bad <= done_bad + 1;
        end
      end
    end
  end

  task automatic clear_mon(input int i);
    #1 mon_clr[i] = 1'b1;
    @(negedge clk);
    #1 mon_clr[i] = 1'b0;
  endtask

  task automatic send_start(input int i);
    @(negedge clk);
    start_r[i] = 1'b1;
    @(posedge clk);
    #1 start_r[i] = 1'b0;
  endtask

  // k counts edges after the start-sampling edge until done is seen high.
  task automatic wait_done(input int i, input int lim, output int k, output bit ok);
    k = 0;
    ok = 1'b0;
    while (k < lim) begin
      @(posedge clk);
      #1 k++;
      if (done_w[i]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_r = 4'hF; start_r = 4'h0; mon_clr = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy_w[i], done_w[i], idx_w[i], din_w[i], mclk_w[i], load_w[i]} !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got busy=%b done=%b idx=%0d din=%b clk=%b load=%b expected all 0",
                 i, busy_w[i], done_w[i], idx_w[i], din_w[i], mclk_w[i], load_w[i]);
      end
    end
    @(negedge clk);
    start_r = 4'hF;
    @(posedge clk);
    #1;
    checks++;
    if (busy_w !== 4'h0) begin
      errors++;
      $display("FAIL reset_priority busy=%b expected 0000", busy_w);
    end
    @(negedge clk);
    start_r = 4'h0; rst_r = 4'h0; mon_clr = 4'h0;
  endtask

  task automatic test_basic();
    int k, tot;
    bit ok;
    tot = dep_of(0) * per_of(0) + 1;
    clear_mon(0);
    repeat ($urandom_range(1, 6)) @(posedge clk);
    send_start(0);
    checks++;
    if (busy_w[0] !== 1'b1 || idx_w[0] !== 4'd0) begin
      errors++;
      $display("FAIL basic_entry busy=%b idx=%0d expected busy=1 idx=0", busy_w[0], idx_w[0]);
    end
    wait_done(0, tot + 20, k, ok);
    // The done pulse occupies the last of tot cycles counted from the start edge.
    checks++;
    if (!ok || k + 1 != tot) begin
      errors++;
      $display("FAIL basic_latency cycles=%0d expected %0d", k + 1, tot);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width done=%b busy=%b expected 0 0", done_w[0], busy_w[0]);
    end
    checks++;
    if (g_mon[0].nframes != dep_of(0)) begin
      errors++;
      $display("FAIL basic_frame_count got %0d expected %0d", g_mon[0].nframes, dep_of(0));
    end
    checks++;
    if (g_mon[0].frames[0][15:0] !== 16'h0C01) begin
      errors++;
      $display("FAIL basic_first_frame got %h expected 0c01", g_mon[0].frames[0][15:0]);
    end
    for (int f = 0; f < dep_of(0); f++) begin
      checks++;
      if (g_mon[0].frames[f] !== exp_frame(0, f) || g_mon[0].fbits[f] != 16) begin
        errors++;
        $display("FAIL basic_frame%0d got %h/%0d bits expected %h/16", f,
                 g_mon[0].frames[f], g_mon[0].fbits[f], exp_frame(0, f));
      end
    end
    checks++;
    if (g_mon[0].stab_err != 0 || g_mon[0].phase_err != 0 || g_mon[0].load_bad != 0 ||
        g_mon[0].done_bad != 0 || g_mon[0].done_cnt != 1) begin
      errors++;
      $display("FAIL basic_timing stab=%0d phase=%0d load=%0d donew=%0d dones=%0d expected 0 0 0 0 1",
               g_mon[0].stab_err, g_mon[0].phase_err, g_mon[0].load_bad,
               g_mon[0].done_bad, g_mon[0].done_cnt);
    end
  endtask

  task automatic test_cascade();
    int k, tot;
    bit ok;
    tot = dep_of(1) * per_of(1) + 1;
    clear_mon(1);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    send_start(1);
    wait_done(1, tot + 20, k, ok);
    checks++;
    if (!ok || k + 1 != tot) begin
      errors++;
      $display("FAIL cascade_latency cycles=%0d expected %0d", k + 1, tot);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (g_mon[1].nframes != dep_of(1)) begin
      errors++;
      $display("FAIL cascade_frame_count got %0d expected %0d", g_mon[1].nframes, dep_of(1));
    end
    for (int f = 0; f < dep_of(1); f++) begin
      checks++;
      if (g_mon[1].frames[f] !== exp_frame(1, f) || g_mon[1].fbits[f] != 64) begin
        errors++;
        $display("FAIL cascade_frame%0d got %h/%0d edges expected %h/64", f,
                 g_mon[1].frames[f], g_mon[1].fbits[f], exp_frame(1, f));
      end
    end
    checks++;
    if (g_mon[1].stab_err != 0 || g_mon[1].phase_err != 0 || g_mon[1].load_bad != 0 ||
        g_mon[1].done_cnt != 1) begin
      errors++;
      $display("FAIL cascade_timing stab=%0d phase=%0d load=%0d dones=%0d expected 0 0 0 1",
               g_mon[1].stab_err, g_mon[1].phase_err, g_mon[1].load_bad, g_mon[1].done_cnt);
    end
  endtask

  task automatic test_busy_start();
    int k, tot;
    bit ok;
    tot = dep_of(2) * per_of(2) + 1;
    clear_mon(2);
    send_start(2);
    k = 0;
    ok = 1'b0;
    while (k < tot + 20) begin
      @(negedge clk);
      start_r[2] = (k < tot - 4) && (k == 3 || $urandom_range(0, 5) == 0);
      @(posedge clk);
      #1 k++;
      if (done_w[2]) begin
        ok = 1'b1;
        break;
      end
    end
    start_r[2] = 1'b0;
    checks++;
    if (!ok || k + 1 != tot) begin
      errors++;
      $display("FAIL busy_start_latency cycles=%0d expected %0d", k + 1, tot);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy_w[2] !== 1'b0 || g_mon[2].done_cnt != 1 || g_mon[2].nframes != dep_of(2)) begin
      errors++;
      $display("FAIL busy_start_single busy=%b dones=%0d frames=%0d expected 0 1 %0d",
               busy_w[2], g_mon[2].done_cnt, g_mon[2].nframes, dep_of(2));
    end
    for (int f = 0; f < dep_of(2); f++) begin
      checks++;
      if (g_mon[2].frames[f] !== exp_frame(2, f)) begin
        errors++;
        $display("FAIL busy_start_frame%0d got %h expected %h", f, g_mon[2].frames[f], exp_frame(2, f));
      end
    end
    checks++;
    if (g_mon[2].stab_err != 0 || g_mon[2].phase_err != 0 || g_mon[2].load_bad != 0) begin
      errors++;
      $display("FAIL din_stable_cd1 stab=%0d phase=%0d load=%0d expected 0 0 0",
               g_mon[2].stab_err, g_mon[2].phase_err, g_mon[2].load_bad);
    end
  endtask

  task automatic test_reset_abort();
    int k, tot, cd;
    bit ok;
    cd = cd_of(0);
    tot = dep_of(0) * per_of(0) + 1;
    clear_mon(0);
    send_start(0);
    k = 0;
    while (idx_w[0] != 4'd3 && k < 5 * per_of(0)) begin
      @(posedge clk);
      #1 k++;
    end
    checks++;
    if (idx_w[0] !== 4'd3) begin
      errors++;
      $display("FAIL abort_reach_cmd3 idx=%0d expected 3", idx_w[0]);
    end
    // Bit 7 of the word is the ninth bit on the wire: cycles [16*CD, 18*CD).
    repeat (16 * cd + $urandom_range(0, 2 * cd - 1)) @(posedge clk);
    @(negedge clk);
    rst_r[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy_w[0], done_w[0], idx_w[0], din_w[0], mclk_w[0], load_w[0]} !== 9'd0) begin
      errors++;
      $display("FAIL abort_outputs busy=%b done=%b idx=%0d din=%b clk=%b load=%b expected all 0",
               busy_w[0], done_w[0], idx_w[0], din_w[0], mclk_w[0], load_w[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_r[0] = 1'b0;
    repeat (8 * cd) @(posedge clk);
    #1;
    checks++;
    if (g_mon[0].nframes != 3 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_latch frames=%0d busy=%b expected 3 0", g_mon[0].nframes, busy_w[0]);
    end
    clear_mon(0);
    send_start(0);
    checks++;
    if (idx_w[0] !== 4'd0 || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart_idx idx=%0d busy=%b expected 0 1", idx_w[0], busy_w[0]);
    end
    wait_done(0, tot + 20, k, ok);
    checks++;
    if (!ok || k + 1 != tot || g_mon[0].nframes != dep_of(0) || g_mon[0].frames[0] !== exp_frame(0, 0)) begin
      errors++;
      $display("FAIL abort_resend cycles=%0d frames=%0d first=%h expected %0d %0d %h",
               k + 1, g_mon[0].nframes, g_mon[0].frames[0], tot, dep_of(0), exp_frame(0, 0));
    end
  endtask

  task automatic test_restart();
    int k, tot;
    bit ok;
    tot = dep_of(2) * per_of(2) + 1;
    repeat (2) @(posedge clk);
    clear_mon(2);
    @(negedge clk);
    start_r[2] = 1'b1;
    wait_done(2, tot + 20, k, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_first_done seen=%0d expected 1", ok);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy_w[2] !== 1'b0 || done_w[2] !== 1'b0) begin
      errors++;
      $display("FAIL restart_idle_cycle busy=%b done=%b expected 0 0", busy_w[2], done_w[2]);
    end
    @(posedge clk);
    #1 start_r[2] = 1'b0;
    checks++;
    if (busy_w[2] !== 1'b1 || idx_w[2] !== 4'd0) begin
      errors++;
      $display("FAIL restart_reentry busy=%b idx=%0d expected 1 0", busy_w[2], idx_w[2]);
    end
    wait_done(2, tot + 20, k, ok);
    checks++;
    if (!ok || k + 1 != tot) begin
      errors++;
      $display("FAIL restart_latency cycles=%0d expected %0d", k + 1, tot);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy_w[2] !== 1'b0 || g_mon[2].done_cnt != 2 || g_mon[2].done_bad != 0) begin
      errors++;
      $display("FAIL restart_done_count busy=%b dones=%0d wide=%0d expected 0 2 0",
               busy_w[2], g_mon[2].done_cnt, g_mon[2].done_bad);
    end
  endtask

  task automatic test_din_stability();
    int k, tot;
    bit ok;
    tot = dep_of(3) * per_of(3) + 1;
    clear_mon(3);
    repeat ($urandom_range(0, 9)) @(posedge clk);
    send_start(3);
    wait_done(3, tot + 20, k, ok);
    checks++;
    if (!ok || k + 1 != tot) begin
      errors++;
      $display("FAIL cd7_latency cycles=%0d expected %0d", k + 1, tot);
    end
    repeat (2) @(posedge clk);
    for (int f = 0; f < dep_of(3); f++) begin
      checks++;
      if (g_mon[3].frames[f] !== exp_frame(3, f) || g_mon[3].fbits[f] != 32) begin
        errors++;
        $display("FAIL cd7_frame%0d got %h/%0d edges expected %h/32", f,
                 g_mon[3].frames[f], g_mon[3].fbits[f], exp_frame(3, f));
      end
    end
    checks++;
    if (g_mon[3].stab_err != 0 || g_mon[3].phase_err != 0 || g_mon[3].load_bad != 0 ||
        g_mon[3].nframes != dep_of(3)) begin
      errors++;
      $display("FAIL din_stable_cd7 stab=%0d phase=%0d load=%0d frames=%0d expected 0 0 0 %0d",
               g_mon[3].stab_err, g_mon[3].phase_err, g_mon[3].load_bad,
               g_mon[3].nframes, dep_of(3));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_cascade();
    test_busy_start();
    test_reset_abort();
    test_restart();
    test_din_stability();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
